// File: rtl/router_xy_crossbar.sv
`default_nettype none
// ============================================================================
// Module      : router_xy_crossbar
// Description : 5-port XY mesh router; per-input FIFOs, per-output round-robin
//               arbitration, held output registers, out-of-grid drop counter.
// Revision    : 1.0 - initial release
// ============================================================================
module router_xy_crossbar #(
    parameter int GRID_ROWS    = 4,
    parameter int GRID_COLS    = 4,
    parameter int ROUTER_ROW   = 0,
    parameter int ROUTER_COL   = 0,
    parameter int PACKET_WIDTH = 32,
    parameter int ROW_LSB      = 2,
    parameter int COL_LSB      = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                         i_clk,
    input  logic                         i_arst_n,
    input  logic [4:0][PACKET_WIDTH-1:0] i_inData,
    input  logic [4:0]                   i_inValid,
    output logic [4:0]                   o_inReady,
    output logic [4:0][PACKET_WIDTH-1:0] o_outData,
    output logic [4:0]                   o_outValid,
    input  logic [4:0]                   i_outReady,
    output logic [15:0]                  o_dropCount
);

    localparam int c_rowW = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1;
    localparam int c_colW = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;
    localparam int c_ptrW = $clog2(FIFO_DEPTH);
    localparam int c_cntW = c_ptrW + 1;

    localparam int c_portNi    = 0;
    localparam int c_portNorth = 1;
    localparam int c_portSouth = 2;
    localparam int c_portEast  = 3;
    localparam int c_portWest  = 4;

    localparam logic [c_rowW-1:0] c_routerRow = c_rowW'(ROUTER_ROW);
    localparam logic [c_colW-1:0] c_routerCol = c_colW'(ROUTER_COL);

    logic [4:0][PACKET_WIDTH-1:0] w_head;
    logic [4:0][4:0]              w_req;      // w_req[input][output]
    logic [4:0]                   w_drop;
    logic [4:0]                   w_pop;
    logic [4:0]                   w_granted;
    logic [4:0]                   w_outFree;
    logic [4:0]                   w_outGrant;
    logic [4:0][2:0]              w_grantIdx;

    logic [4:0][PACKET_WIDTH-1:0] r_outData;
    logic [4:0]                   r_outValid;
    logic [4:0][2:0]              r_ptr;
    logic [15:0]                  r_dropCount;

    genvar p;
    generate
        for (p = 0; p < 5; p++) begin : g_port
            logic [PACKET_WIDTH-1:0] r_mem [FIFO_DEPTH];
            logic [c_ptrW-1:0]       r_wrPtr;
            logic [c_ptrW-1:0]       r_rdPtr;
            logic [c_cntW-1:0]       r_count;
            logic                    w_full;
            logic                    w_push;
            logic                    w_headValid;
            logic [c_rowW-1:0]       w_dRow;
            logic [c_colW-1:0]       w_dCol;
            logic [4:0]              w_route;

            assign w_full       = (r_count == c_cntW'(FIFO_DEPTH));
            assign w_push       = i_inValid[p] && !w_full;
            assign o_inReady[p] = !w_full;
            assign w_headValid  = (r_count != '0);

            // Storage carries no reset; occupancy alone defines validity.
            always_ff @(posedge i_clk) begin
                if (w_push) begin
                    r_mem[r_wrPtr] <= i_inData[p];
                end
            end

            always_ff @(posedge i_clk or negedge i_arst_n) begin
                if (!i_arst_n) begin
                    r_wrPtr <= '0;
                    r_rdPtr <= '0;
                    r_count <= '0;
                end else begin
                    if (w_push) begin
                        r_wrPtr <= r_wrPtr + 1'b1;
                    end
                    if (w_pop[p]) begin
                        r_rdPtr <= r_rdPtr + 1'b1;
                    end
                    case ({w_push, w_pop[p]})
                        2'b10:   r_count <= r_count + 1'b1;
                        2'b01:   r_count <= r_count - 1'b1;
                        default: r_count <= r_count;
                    endcase
                end
            end

            assign w_head[p] = r_mem[r_rdPtr];
            assign w_dRow    = w_head[p][ROW_LSB +: c_rowW];
            assign w_dCol    = w_head[p][COL_LSB +: c_colW];
            assign w_drop[p] = w_headValid &&
                               ((32'(w_dRow) >= GRID_ROWS) || (32'(w_dCol) >= GRID_COLS));

            // Column first, then row: plain XY dimension-order routing.
            always_comb begin
                w_route = '0;
                if (w_dCol > c_routerCol) begin
                    w_route[c_portEast] = 1'b1;
                end else if (w_dCol < c_routerCol) begin
                    w_route[c_portWest] = 1'b1;
                end else if (w_dRow > c_routerRow) begin
                    w_route[c_portSouth] = 1'b1;
                end else if (w_dRow < c_routerRow) begin
                    w_route[c_portNorth] = 1'b1;
                end else begin
                    w_route[c_portNi] = 1'b1;
                end
            end

            assign w_req[p] = (w_headValid && !w_drop[p]) ? w_route : 5'b0;
        end
    endgenerate

    assign w_outFree = ~r_outValid | i_outReady;

    // Round-robin per output, searching from r_ptr; each input requests one output only.
    always_comb begin
        logic [3:0] sum;
        logic [2:0] idx;
        w_outGrant = '0;
        w_grantIdx = '0;
        w_granted  = '0;
        sum        = '0;
        idx        = '0;
        for (int o = 0; o < 5; o++) begin
            for (int k = 0; k < 5; k++) begin
                sum = {1'b0, r_ptr[o]} + 4'(k);
                idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
                if (w_outFree[o] && !w_outGrant[o] && w_req[idx][o]) begin
                    w_outGrant[o] = 1'b1;
                    w_grantIdx[o] = idx;
                    w_granted[idx] = 1'b1;
                end
            end
        end
    end

    assign w_pop = w_granted | w_drop;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_outData  <= '0;
            r_outValid <= '0;
            r_ptr      <= '0;
        end else begin
            for (int o = 0; o < 5; o++) begin
                if (w_outGrant[o]) begin
                    r_outData[o]  <= w_head[w_grantIdx[o]];
                    r_outValid[o] <= 1'b1;
                    r_ptr[o]      <= (w_grantIdx[o] == 3'd4) ? 3'd0 : w_grantIdx[o] + 3'd1;
                end else if (w_outFree[o]) begin
                    r_outData[o]  <= '0;
                    r_outValid[o] <= 1'b0;
                end
            end
        end
    end

    logic [2:0]  w_dropNum;
    logic [16:0] w_dropSum;

    always_comb begin
        w_dropNum = '0;
        for (int i = 0; i < 5; i++) begin
            w_dropNum = w_dropNum + {2'b00, w_drop[i]};
        end
    end

    assign w_dropSum = {1'b0, r_dropCount} + 17'(w_dropNum);

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_dropCount <= '0;
        end else begin
            r_dropCount <= w_dropSum[16] ? 16'hFFFF : w_dropSum[15:0];
        end
    end

    assign o_outData   = r_outData;
    assign o_outValid  = r_outValid;
    assign o_dropCount = r_dropCount;

endmodule
`default_nettype wire

// File: doc/router_xy_crossbar.md
Name: router_xy_crossbar

Overview:
- Parametrised next-generation 5-port XY mesh router for the NoC.
- Each input port is buffered in a FIFO. Output ports are independently arbitrated by per-output round-robin, so up to five packets move per cycle.
- Output registers hold their packet until the downstream side accepts it; a packet is never overwritten or lost under backpressure.
- Adds rectangular grid support, configurable address field positions, and an error counter for out-of-grid destinations.

Parameters:
- GRID_ROWS, 4, mesh rows, ≥2.
- GRID_COLS, 4, mesh columns, ≥2.
- ROUTER_ROW, 0, this router's row, < GRID_ROWS.
- ROUTER_COL, 0, this router's column, < GRID_COLS.
- PACKET_WIDTH, 32, packet width in bits.
- ROW_LSB, 2, LSB of the destination row field; field width ROW_W=$clog2(GRID_ROWS).
- COL_LSB, 0, LSB of the destination column field; field width COL_W=$clog2(GRID_COLS).
- FIFO_DEPTH, 4, entries per input FIFO, power of 2, ≥2.

Ports:
- i_clk  in  1  clock
- i_arst_n  in  1  reset, asynchronous, active-low
- i_inData  in  [5][PACKET_WIDTH]  input packets; index 0=NI, 1=NORTH, 2=SOUTH, 3=EAST, 4=WEST (same indexing on all arrays)
- i_inValid  in  5  input valid per port
- o_inReady  out  5  input ready per port
- o_outData  out  [5][PACKET_WIDTH]  output packets, registered
- o_outValid  out  5  output valid per port, registered
- i_outReady  in  5  downstream ready per port
- o_dropCount  out  16  count of dropped out-of-grid packets, saturating

Behaviour:
- Reset (async assert, sync release):
  - All FIFOs empty; o_outValid=0, o_outData='0, o_dropCount=0.
  - All arbiter pointers=0; o_inReady=5'b11111.
  - Mid-operation reset discards all buffered and output packets immediately.
- Input FIFOs:
  - o_inReady[p]=!full[p], combinational from the occupancy count.
  - Write occurs only when i_inValid[p] && o_inReady[p]; valid while full is ignored and creates no write.
  - Simultaneous pop and push leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - FIFOs are not fall-through: a written entry becomes the head on the next cycle.
- Route computation, from head[p] fields dRow and dCol:
  - dCol>ROUTER_COL → EAST; dCol<ROUTER_COL → WEST.
  - else dRow>ROUTER_ROW → SOUTH; dRow<ROUTER_ROW → NORTH.
  - else → NI.
  - All comparisons are unsigned.
- Drop rule:
  - If dRow≥GRID_ROWS or dCol≥GRID_COLS, the head is popped in that cycle without arbitration and o_dropCount increments next cycle.
  - o_dropCount saturates at 16'hFFFF.
  - If several heads drop in the same cycle, the count increases by their number, saturating.
- Per-output arbiter o:
  - Requesters: non-empty, non-dropping heads routed to o.
  - o is free when !o_outValid[o] || i_outReady[o]; a grant is issued only when o is free.
  - Round-robin search starts at ptr[o]; after a grant, ptr[o]=(granted+1) mod 5; with no grant, ptr is unchanged.
  - Each input requests at most one output, so grants never conflict; a granted input is popped the same cycle.
- Output register:
  - On grant: o_outData[o]<=head, o_outValid[o]<=1.
  - If free with no grant: o_outValid[o]<=0, o_outData[o]<='0.
  - While valid && !ready, data and valid hold stable.
- Latency:
  - Write at cycle t → output valid at t+2 when uncontended.
  - Sustained throughput is 1 packet/cycle/output under continuous ready.
- U-turns (route equal to input port) are not filtered; they are forwarded like any other packet.

Test Plan:
All scenarios use defaults with ROUTER_ROW=1, ROUTER_COL=1 unless stated.

1. Reset: assert i_arst_n=0 mid-traffic → o_outValid=0, o_inReady=5'b11111, o_dropCount=0 in the same cycle, with no clock edge needed.
2. Routing:
   - NI injects dest {row=1,col=3} at t → o_outValid[EAST]=1 at t+2 with the same data.
   - {1,0} → WEST; {3,1} → SOUTH; {0,1} → NORTH; {1,1} → NI.
3. Parallel forwarding: N injects {1,1} and W injects {1,3} in the same cycle → o_outValid[NI] and o_outValid[EAST] both assert at t+2.
4. Round-robin contention: NI, N, S, W all stream dest {1,3} with i_outReady[EAST]=1 → EAST grant order is 0,1,2,4,0,1,… (port 3 is skipped as it has no request).
5. Backpressure:
   - Hold i_outReady[EAST]=0 and inject 6 packets from NI to {1,2} → first packet stable on o_outData[EAST].
   - The NI FIFO accepts 4 more; o_inReady[0]=0 after the 5th accept.
   - Release ready → all 5 accepted packets emerge in order with no loss.
6. Drop: GRID_COLS=3, inject {1,3} → no output valid, o_dropCount=1. Preload o_dropCount=16'hFFFF via 65535 drops, then one more drop → o_dropCount stays at 16'hFFFF.
